// File: rtl/ahb2apb_bridge_core.sv
// ahb2apb_bridge_core
//   AHB-Lite slave to APB master bridge. Single NONSEQ/SEQ transfers that hit
//   0x8000_0000..0x8BFF_FFFF are re-issued as a two-cycle APB transfer
//   (SETUP then ENABLE) on one of three one-hot peripheral selects. The AHB
//   side is stalled through hready_out while an APB transfer it depends on
//   is still in flight.
//
// Ports
//   hclk        in   clock, all state on the rising edge
//   hresetn     in   asynchronous reset, ACTIVE HIGH despite the name
//   hwrite      in   AHB direction, 1 = write
//   hready_in   in   AHB ready seen by the master; transfers sampled only when 1
//   htrans      in   AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwdata      in   AHB write data, valid in the data phase
//   haddr       in   AHB address
//   pr_data     in   APB read data
//   penable     out  APB enable (ENABLE phase)
//   pwrite      out  APB direction
//   hready_out  out  AHB ready to master, 0 stalls
//   psel        out  one-hot APB select (001 / 010 / 100)
//   hres        out  AHB response, always OKAY
//   paddr       out  APB address
//   pwdata      out  APB write data
//   hr_data     out  AHB read data (pass-through of pr_data)

module ahb2apb_bridge_core #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hwrite,
    input  logic              hready_in,
    input  logic [1:0]        htrans,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] pr_data,
    output logic              penable,
    output logic              pwrite,
    output logic              hready_out,
    output logic [2:0]        psel,
    output logic [1:0]        hres,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] hr_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(32'h8000_0000);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(32'h8C00_0000);

    // Each select covers a 64 MB slice; bits [27:26] pick the slice inside the window.
    function automatic logic [2:0] f_decode(input logic [1:0] slice);
        case (slice)
            2'b00:   f_decode = 3'b001;
            2'b01:   f_decode = 3'b010;
            2'b10:   f_decode = 3'b100;
            default: f_decode = 3'b000;
        endcase
    endfunction

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_1;
    logic              r_hwrite_reg;
    logic [2:0]        r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_hready_out;

    logic w_xfer;
    logic w_in_range;
    logic w_valid;

    assign w_xfer     = (htrans == 2'b10) || (htrans == 2'b11);
    assign w_in_range = (haddr >= BASE) && (haddr < LIMIT);
    assign w_valid    = hready_in && w_xfer && w_in_range;

    // Address-phase capture. A write's address waits here until its data phase
    // arrives; a transfer queued behind a write waits here until the write's
    // ENABLE cycle.
    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            r_addr_1     <= '0;
            r_hwrite_reg <= 1'b0;
        end else if (hready_in) begin
            r_addr_1     <= haddr;
            r_hwrite_reg <= hwrite;
        end
    end

    // Outputs are set on the edge that enters each state, so SETUP values come
    // from the live bus (haddr/hwdata) or from r_addr_1 before it is overwritten.
    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            r_state      <= ST_IDLE;
            r_psel       <= 3'b000;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_hready_out <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    r_penable <= 1'b0;
                    if (w_valid && !hwrite) begin
                        r_state      <= ST_READ;
                        r_psel       <= f_decode(haddr[27:26]);
                        r_paddr      <= haddr;
                        r_pwrite     <= 1'b0;
                        r_hready_out <= 1'b0;
                    end else begin
                        r_state      <= w_valid ? ST_WWAIT : ST_IDLE;
                        r_psel       <= 3'b000;
                        r_pwrite     <= 1'b0;
                        r_hready_out <= 1'b1;
                    end
                end
                ST_WWAIT: begin
                    // hwdata belongs to the write captured in r_addr_1; a new
                    // address in the same cycle is queued and stalls one cycle.
                    r_state      <= w_valid ? ST_WRITEP : ST_WRITE;
                    r_psel       <= f_decode(r_addr_1[27:26]);
                    r_paddr      <= r_addr_1;
                    r_pwdata     <= hwdata;
                    r_pwrite     <= 1'b1;
                    r_penable    <= 1'b0;
                    r_hready_out <= !w_valid;
                end
                ST_READ: begin
                    r_state      <= ST_RENABLE;
                    r_penable    <= 1'b1;
                    r_hready_out <= 1'b1;
                end
                ST_WRITE: begin
                    r_state      <= w_valid ? ST_WENABLEP : ST_WENABLE;
                    r_penable    <= 1'b1;
                    // A read queued here must keep its data phase open until
                    // its own ENABLE returns pr_data.
                    r_hready_out <= !w_valid || hwrite;
                end
                ST_WRITEP: begin
                    r_state      <= ST_WENABLEP;
                    r_penable    <= 1'b1;
                    r_hready_out <= r_hwrite_reg;
                end
                ST_WENABLEP: begin
                    r_penable <= 1'b0;
                    r_psel    <= f_decode(r_addr_1[27:26]);
                    r_paddr   <= r_addr_1;
                    r_pwrite  <= r_hwrite_reg;
                    if (!r_hwrite_reg) begin
                        r_state      <= ST_READ;
                        r_hready_out <= 1'b0;
                    end else begin
                        r_pwdata     <= hwdata;
                        r_state      <= w_valid ? ST_WRITEP : ST_WRITE;
                        r_hready_out <= !w_valid;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_psel       <= 3'b000;
                    r_penable    <= 1'b0;
                    r_hready_out <= 1'b1;
                end
            endcase
        end
    end

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign hready_out = r_hready_out;
    assign hres       = 2'b00;
    assign hr_data    = pr_data;

endmodule

// File: tb/tb_ahb2apb_bridge_core.sv
module tb_ahb2apb_bridge_core;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hwrite;
    logic        hready_in;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] haddr;
    logic [31:0] pr_data;
    logic        penable;
    logic        pwrite;
    logic        hready_out;
    logic [2:0]  psel;
    logic [1:0]  hres;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hr_data;

    bit force_low = 1'b0;
    bit pr_fixed  = 1'b0;

    // The bridge is the only slave, so the master sees its own hready_out.
    assign hready_in = hready_out & ~force_low;

    always #5 hclk = ~hclk;

    ahb2apb_bridge_core #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
        .htrans(htrans), .hwdata(hwdata), .haddr(haddr), .pr_data(pr_data),
        .penable(penable), .pwrite(pwrite), .hready_out(hready_out), .psel(psel),
        .hres(hres), .paddr(paddr), .pwdata(pwdata), .hr_data(hr_data)
    );

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } xfer_t;
    typedef struct { logic [1:0] t; logic w; logic [31:0] a; logic [31:0] d; } op_t;
    typedef struct { logic [2:0] sel; logic w; logic [31:0] a; logic [31:0] d; } apb_t;

    xfer_t       exp_q[$];   // APB transfers the bus must still produce, in order
    apb_t        done_q[$];  // APB transfers observed completing
    logic [31:0] rd_q[$];    // read data seen on APB ENABLE, owed to the AHB master
    op_t         op_q[$];    // AHB address phases still to issue

    int n_checks = 0;
    int n_err    = 0;
    int n_stall  = 0;
    int n_active = 0;

    bit          dp_on = 1'b0;
    logic        dp_w;
    logic [31:0] dp_a, dp_d, ap_d, last_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8C00_0000);
    endfunction

    function automatic logic [2:0] sel_of(input logic [31:0] a);
        int slot;
        slot = int'((a - 32'h8000_0000) / 32'h0400_0000);
        return 3'(1 << slot);
    endfunction

    // ---------------- APB-side compare process ----------------
    bit    m_setup = 1'b0;
    apb_t  m_snap;
    xfer_t m_cur;

    always @(negedge hclk) begin
        if (hresetn) begin
            m_setup = 1'b0;
        end else begin
            if (!hready_out) n_stall++;
            if (psel != 3'b000) n_active++;
            chk("hres", 32'(hres), 32'h0);
            chk("hr_data_pass", hr_data, pr_data);
            if (psel == 3'b000) chk("penable_idle", 32'(penable), 32'h0);
            if (m_setup) begin
                m_setup = 1'b0;
                chk("enable_follows_setup", 32'(penable), 32'h1);
                chk("psel_stable", 32'(psel), 32'(m_snap.sel));
                chk("paddr_stable", paddr, m_snap.a);
                chk("pwrite_stable", 32'(pwrite), 32'(m_snap.w));
                if (m_snap.w) chk("pwdata_stable", pwdata, m_snap.d);
                if (penable && psel != 3'b000) begin
                    done_q.push_back('{psel, pwrite, paddr, pwdata});
                    if (!pwrite) rd_q.push_back(pr_data);
                end
            end else if (psel != 3'b000) begin
                chk("setup_penable", 32'(penable), 32'h0);
                chk("setup_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    m_cur = exp_q.pop_front();
                    chk("setup_psel", 32'(psel), 32'(sel_of(m_cur.a)));
                    chk("setup_paddr", paddr, m_cur.a);
                    chk("setup_pwrite", 32'(pwrite), 32'(m_cur.w));
                    if (m_cur.w) chk("setup_pwdata", pwdata, m_cur.d);
                end
                m_snap  = '{psel, pwrite, paddr, pwdata};
                m_setup = 1'b1;
            end
        end
    end

    // ---------------- AHB master model, one cycle per call ----------------
    task automatic step();
        bit  rdy;
        op_t op;
        @(negedge hclk);
        #1;
        rdy = hready_in;
        if (rdy) begin
            // data phase in progress completes at the coming edge
            if (dp_on && in_win(dp_a)) begin
                if (dp_w) begin
                    exp_q.push_back('{1'b1, dp_a, dp_d});
                end else begin
                    chk("rd_data_available", 32'(rd_q.size() > 0), 32'h1);
                    if (rd_q.size() > 0) begin
                        last_rd = hr_data;
                        chk("rd_data", hr_data, rd_q.pop_front());
                    end
                end
            end
            // address phase on the bus is accepted
            dp_on = htrans[1];
            dp_w  = hwrite;
            dp_a  = haddr;
            dp_d  = ap_d;
            if (dp_on && in_win(dp_a) && !dp_w) exp_q.push_back('{1'b0, dp_a, 32'h0});
        end
        @(posedge hclk);
        #1;
        if (rdy) begin
            hwdata = (dp_on && dp_w) ? dp_d : $urandom;
            if (op_q.size() > 0) begin
                op     = op_q.pop_front();
                htrans = op.t;
                hwrite = op.w;
                haddr  = op.a;
                ap_d   = op.d;
            end else begin
                htrans = 2'b00;
                hwrite = 1'($urandom);
                haddr  = $urandom;
                ap_d   = $urandom;
            end
        end
        pr_data = pr_fixed ? 32'h1234_5678 : $urandom;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (k < budget && !(op_q.size() == 0 && !dp_on && htrans == 2'b00 &&
                               exp_q.size() == 0 && psel == 3'b000 && !penable)) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, limit %0d", k, budget);
        end
    endtask

    task automatic clr();
        done_q.delete();
        n_stall  = 0;
        n_active = 0;
    endtask

    task automatic chk_done(input string nm, input int idx, input logic [2:0] sel,
                            input logic w, input logic [31:0] a, input logic [31:0] d);
        chk({nm, "_present"}, 32'(done_q.size() > idx), 32'h1);
        if (done_q.size() > idx) begin
            chk({nm, "_psel"}, 32'(done_q[idx].sel), 32'(sel));
            chk({nm, "_pwrite"}, 32'(done_q[idx].w), 32'(w));
            chk({nm, "_paddr"}, done_q[idx].a, a);
            if (w) chk({nm, "_pwdata"}, done_q[idx].d, d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit %0d", 1_000_000);
        $fatal(1);
    end

    initial begin
        logic [31:0] edges[8];
        int          n_valid;
        int          k;
        op_t         op;
        edges = '{32'h8000_0000, 32'h83FF_FFFC, 32'h8400_0000, 32'h87FF_FFFC,
                  32'h8800_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
        hresetn = 1'b0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        haddr   = 32'h0;
        hwdata  = 32'h0;
        pr_data = 32'h0;
        ap_d    = 32'h0;
        last_rd = 32'h0;
        #1 hresetn = 1'b1;

        // 1: reset values
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'h0);
        chk("rst_hready_out", 32'(hready_out), 32'h1);
        chk("rst_hres", 32'(hres), 32'h0);
        hresetn = 1'b0;

        // 2: single write
        clr();
        op_q.push_back('{2'b10, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5});
        drain(40);
        chk("t2_count", 32'(done_q.size()), 32'd1);
        chk_done("t2", 0, 3'b001, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5);
        chk("t2_stalls", 32'(n_stall), 32'd0);
        chk("t2_psel_after", 32'(psel), 32'h0);

        // 3: single read, one stall cycle
        clr();
        pr_fixed = 1'b1;
        op_q.push_back('{2'b10, 1'b0, 32'h8400_0010, 32'h0});
        drain(40);
        pr_fixed = 1'b0;
        chk_done("t3", 0, 3'b010, 1'b0, 32'h8400_0010, 32'h0);
        chk("t3_hr_data", last_rd, 32'h1234_5678);
        chk("t3_stalls", 32'(n_stall), 32'd1);

        // 4: nothing reaches APB for out-of-window or non-transfer cycles
        clr();
        op_q.push_back('{2'b10, 1'b1, 32'h9000_0000, 32'h1});
        op_q.push_back('{2'b00, 1'b1, 32'h8000_0000, 32'h2});
        op_q.push_back('{2'b01, 1'b0, 32'h8000_0004, 32'h3});
        op_q.push_back('{2'b10, 1'b0, 32'h7FFF_FFFC, 32'h4});
        op_q.push_back('{2'b11, 1'b1, 32'h8C00_0000, 32'h5});
        drain(40);
        force_low = 1'b1;
        htrans    = 2'b10;
        hwrite    = 1'b1;
        haddr     = 32'h8000_0040;
        repeat (4) step();
        htrans    = 2'b00;
        force_low = 1'b0;
        drain(40);
        chk("t4_active", 32'(n_active), 32'd0);
        chk("t4_stalls", 32'(n_stall), 32'd0);
        chk("t4_count", 32'(done_q.size()), 32'd0);

        // 4b: last words of the top two slices
        clr();
        op_q.push_back('{2'b10, 1'b1, 32'h87FF_FFFC, 32'hCAFE_0001});
        op_q.push_back('{2'b11, 1'b0, 32'h8BFF_FFFC, 32'h0});
        drain(40);
        chk_done("t4b_w", 0, 3'b010, 1'b1, 32'h87FF_FFFC, 32'hCAFE_0001);
        chk_done("t4b_r", 1, 3'b100, 1'b0, 32'h8BFF_FFFC, 32'h0);

        // 5: back-to-back writes
        clr();
        op_q.push_back('{2'b10, 1'b1, 32'h8800_0000, 32'h1111_2222});
        op_q.push_back('{2'b11, 1'b1, 32'h8800_0004, 32'h3333_4444});
        drain(40);
        chk("t5_count", 32'(done_q.size()), 32'd2);
        chk_done("t5a", 0, 3'b100, 1'b1, 32'h8800_0000, 32'h1111_2222);
        chk_done("t5b", 1, 3'b100, 1'b1, 32'h8800_0004, 32'h3333_4444);
        chk("t5_stalls", 32'(n_stall), 32'd1);

        // 6: reset during a write ENABLE aborts it
        clr();
        op_q.push_back('{2'b10, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF});
        k = 0;
        while (k < 10 && !penable) begin
            step();
            k++;
        end
        chk("t6_reached_enable", 32'(penable), 32'h1);
        hresetn = 1'b1;
        #1;
        chk("t6_penable", 32'(penable), 32'h0);
        chk("t6_psel", 32'(psel), 32'h0);
        chk("t6_hready_out", 32'(hready_out), 32'h1);
        exp_q.delete();
        rd_q.delete();
        op_q.delete();
        dp_on  = 1'b0;
        htrans = 2'b00;
        @(posedge hclk);
        #1;
        hresetn = 1'b0;
        clr();
        op_q.push_back('{2'b10, 1'b0, 32'h8800_0008, 32'h0});
        drain(40);
        chk("t6_count", 32'(done_q.size()), 32'd1);
        chk_done("t6_after", 0, 3'b100, 1'b0, 32'h8800_0008, 32'h0);

        // randomized traffic against the queue model
        clr();
        n_valid = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            r    = $urandom_range(0, 99);
            op.t = (r < 15) ? 2'b00 : (r < 20) ? 2'b01 : (r < 60) ? 2'b10 : 2'b11;
            op.w = 1'($urandom);
            op.d = $urandom;
            r    = $urandom_range(0, 99);
            if (r < 10)      op.a = edges[$urandom_range(0, 7)];
            else if (r < 85) op.a = 32'h8000_0000 + ($urandom_range(0, 32'h0BFF_FFFF) & ~32'h3);
            else             op.a = $urandom;
            if (op.t[1] && in_win(op.a)) n_valid++;
            op_q.push_back(op);
        end
        drain(5000);
        chk("rand_count", 32'(done_q.size()), 32'(n_valid));
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
